// File: rtl/pio_arb_pkg.sv
// rtl/pio_arb_pkg.sv - shared constants and state encoding for the PIO access arbiter
// PIO_ARB_READBACK_EN adds the READBACK state.
package pio_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int TXN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
`ifdef PIO_ARB_READBACK_EN
    ST_RESP     = 2'd2,
    ST_READBACK = 2'd3
`else
    ST_RESP     = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/pio_arb_rr_pick.sv
// rtl/pio_arb_rr_pick.sv - two-way round-robin pick; on contention the requester not granted last wins
module pio_arb_rr_pick
  import pio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last_grant,
  output logic               o_grant,
  output logic               o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = 1'b0;
    if (i_req[0] && i_req[1]) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req[1];
    end
  end

endmodule

// File: rtl/pio_access_arbiter.sv
// rtl/pio_access_arbiter.sv - arbitrates two requesters onto one Avalon-MM PIO slave port
// Build option PIO_ARB_READBACK_EN: verify each write with a readback cycle and flag mismatches on err.
module pio_access_arbiter
  import pio_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     we,
  input  logic [2*ADDR_W-1:0]    addr,
  input  logic [2*DATA_W-1:0]    wdata,
  output logic [NUM_REQ-1:0]     ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [TXN_CNT_W-1:0]   txn_count,
  output logic [ADDR_W-1:0]      pio_address,
  output logic                   pio_chipselect,
  output logic                   pio_write_n,
  output logic [DATA_W-1:0]      pio_writedata,
  input  logic [DATA_W-1:0]      pio_readdata
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_grant;
  logic                   r_last_grant;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rdata;
  logic [TXN_CNT_W-1:0]   r_txn_count;

  logic                   w_pick;
  logic                   w_pick_valid;
  logic                   w_grant_now;
  logic                   w_capture;
  logic                   w_cs;
  logic                   w_write_n;
  logic [NUM_REQ-1:0]     w_ack;
  logic [ADDR_W-1:0]      w_addr_sel;
  logic [DATA_W-1:0]      w_wdata_sel;

  pio_arb_rr_pick u_rr_pick (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_valid      (w_pick_valid)
  );

  assign w_addr_sel  = w_pick ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
  assign w_wdata_sel = w_pick ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_now = 1'b0;
    w_capture   = 1'b0;
    w_cs        = 1'b0;
    w_write_n   = 1'b1;
    w_ack       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_now = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_cs      = 1'b1;
        w_write_n = ~r_we;
        w_capture = ~r_we;
`ifdef PIO_ARB_READBACK_EN
        w_state_nxt = r_we ? ST_READBACK : ST_RESP;
`else
        w_state_nxt = ST_RESP;
`endif
      end
`ifdef PIO_ARB_READBACK_EN
      ST_READBACK: begin
        w_cs        = 1'b1;
        w_capture   = 1'b1;
        w_state_nxt = ST_RESP;
      end
`endif
      ST_RESP: begin
        w_ack        = r_grant ? 2'b10 : 2'b01;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_txn_count  <= '0;
    end else begin
      if (w_grant_now) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_we         <= we[w_pick];
        r_addr       <= w_addr_sel;
        r_wdata      <= w_wdata_sel;
      end
      if (w_capture) begin
        r_rdata <= pio_readdata;
      end
      // Saturate so a long-running system never reports a small count after wrap.
      if (r_state == ST_RESP && r_txn_count != {TXN_CNT_W{1'b1}}) begin
        r_txn_count <= r_txn_count + 1'b1;
      end
    end
  end

`ifdef PIO_ARB_READBACK_EN
  logic r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_grant_now) begin
      r_err <= 1'b0;
    end else if (r_state == ST_READBACK) begin
      r_err <= (pio_readdata != r_wdata);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign ack            = w_ack;
  assign rdata          = r_rdata;
  assign txn_count      = r_txn_count;
  assign pio_address    = r_addr;
  assign pio_chipselect = w_cs;
  assign pio_write_n    = w_write_n;
  assign pio_writedata  = r_wdata;

endmodule

// File: tb/tb_pio_access_arbiter.sv
// tb/tb_pio_access_arbiter.sv - self-checking bench for pio_access_arbiter (PIO_ARB_READBACK_EN aware)
module tb_pio_access_arbiter;

`ifdef PIO_ARB_READBACK_EN
  localparam logic RB   = 1'b1;
  localparam int   WLAT = 3;
`else
  localparam logic RB   = 1'b0;
  localparam int   WLAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  b_req = '0;
  logic [1:0]  b_we = '0;
  logic [3:0]  b_addr = '0;
  logic [63:0] b_wdata = '0;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic [15:0] txn_count;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  int vectors = 0;
  int miscompares = 0;

  pio_access_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (b_req),
    .we             (b_we),
    .addr           (b_addr),
    .wdata          (b_wdata),
    .ack            (ack),
    .rdata          (rdata),
    .err            (err),
    .txn_count      (txn_count),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
  );

  always #5 clk = ~clk;

  // PIO slave: address 1 is an input-only register that reads 0 and ignores writes.
  logic [31:0] pio_mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  assign pio_readdata = (pio_address == 2'd1) ? 32'h0 : pio_mem[pio_address];
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address != 2'd1) pio_mem[pio_address] <= pio_writedata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    b_req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic w, input logic [1:0] a, input logic [31:0] d);
    b_req[r] = 1'b1;
    b_we[r] = w;
    b_addr[r*2 +: 2] = a;
    b_wdata[r*32 +: 32] = d;
  endtask

  task automatic do_txn(input int r, input logic w, input logic [1:0] a, input logic [31:0] d,
                        output int lat, output logic [1:0] ackv, output logic [31:0] rd,
                        output logic e, output int cs_cyc, output int wn_low, output logic [31:0] wd);
    lat = 0; cs_cyc = 0; wn_low = 0; ackv = '0; rd = '0; e = 1'b0; wd = '0;
    set_req(r, w, a, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (pio_chipselect) cs_cyc++;
      if (pio_chipselect && !pio_write_n) begin
        wn_low++;
        wd = pio_writedata;
      end
      if (ack != 0) begin
        ackv = ack; rd = rdata; e = err;
        break;
      end
    end
    b_req[r] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int          r;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    int          exp_lat;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  // Reference model state for the random phase.
  logic [31:0] ref_mem [4];
  int          m_busy, m_cnt, m_g, last_g, m_count;
  logic        m_chk, m_err;
  logic [31:0] m_rd;

  initial begin
    int lat, cs_cyc, wn_low;
    logic [1:0] ackv;
    logic [31:0] rd, wd;
    logic e;
    logic [1:0] order [4];
    int n_ack;

    tbl[0] = '{0, 1'b1, 2'd0, 32'hDEADBEEF, WLAT, RB,   32'hDEADBEEF, 1'b0};
    tbl[1] = '{0, 1'b1, 2'd1, 32'h12345678, WLAT, RB,   32'h0,        RB};
    tbl[2] = '{1, 1'b1, 2'd0, 32'h000000A5, WLAT, RB,   32'h000000A5, 1'b0};
    tbl[3] = '{0, 1'b0, 2'd0, 32'h0,        2,    1'b1, 32'h000000A5, 1'b0};
    tbl[4] = '{1, 1'b0, 2'd1, 32'h0,        2,    1'b1, 32'h0,        1'b0};
    tbl[5] = '{1, 1'b1, 2'd3, 32'hCAFEF00D, WLAT, RB,   32'hCAFEF00D, 1'b0};
    tbl[6] = '{0, 1'b0, 2'd3, 32'h0,        2,    1'b1, 32'hCAFEF00D, 1'b0};

    apply_reset();
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_wn", pio_write_n, 1);
    chk("rst_addr", pio_address, 0);
    chk("rst_wd", pio_writedata, 0);

    foreach (tbl[i]) begin
      do_txn(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, lat, ackv, rd, e, cs_cyc, wn_low, wd);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_ack", i), ackv, (tbl[i].r == 1) ? 2'b10 : 2'b01);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_cs_cycles", i), cs_cyc, tbl[i].exp_lat - 1);
      chk($sformatf("tbl%0d_write_cycles", i), wn_low, tbl[i].w ? 1 : 0);
      if (tbl[i].w) chk($sformatf("tbl%0d_wdata", i), wd, tbl[i].d);
    end
    chk("txn_after_table", txn_count, 7);

    // Contention from reset: grants must alternate starting with requester 0.
    apply_reset();
    set_req(0, 1'b0, 2'd0, 32'h0);
    set_req(1, 1'b0, 2'd2, 32'h0);
    n_ack = 0;
    for (int k = 0; k < 40 && n_ack < 4; k++) begin
      @(negedge clk);
      if (ack != 0) begin
        order[n_ack] = ack;
        n_ack++;
      end
    end
    b_req = '0;
    @(negedge clk);
    chk("rr_ack_count", n_ack, 4);
    for (int k = 0; k < n_ack; k++) chk($sformatf("rr_grant%0d", k), order[k], (k % 2) ? 2'b10 : 2'b01);

    // Reset while an access is on the bus: aborted, no ack, counter cleared.
    set_req(0, 1'b1, 2'd0, 32'h11111111);
    n_ack = 0;
    for (int k = 0; k < 10 && !pio_chipselect; k++) @(negedge clk);
    chk("abort_saw_cs", pio_chipselect, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_cs", pio_chipselect, 0);
    chk("abort_wn", pio_write_n, 1);
    chk("abort_ack", ack, 0);
    chk("abort_txn", txn_count, 0);
    b_req = '0;
    repeat (3) begin
      @(negedge clk);
      if (ack != 0) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(0, 1'b0, 2'd3, 32'h0, lat, ackv, rd, e, cs_cyc, wn_low, wd);
    chk("post_abort_lat", lat, 2);
    chk("post_abort_rdata", rd, 32'hCAFEF00D);
    do_txn(1, 1'b0, 2'd0, 32'h0, lat, ackv, rd, e, cs_cyc, wn_low, wd);
    chk("aborted_write_absent", rd, 32'h000000A5);
    chk("post_abort_txn", txn_count, 2);

    // Counter saturation from a preloaded value.
    force dut.r_txn_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_txn_count;
    @(negedge clk);
    chk("sat_preload", txn_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) do_txn(k % 2, 1'b0, 2'd0, 32'h0, lat, ackv, rd, e, cs_cyc, wn_low, wd);
    chk("sat_hold", txn_count, 16'hFFFF);

    // Random traffic against the transaction-level model.
    apply_reset();
    for (int i = 0; i < 4; i++) ref_mem[i] = pio_mem[i];
    m_busy = 0; m_cnt = 0; m_g = 0; last_g = 1; m_count = 0;
    m_chk = 0; m_err = 0; m_rd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [1:0] exp_ack;
      exp_ack = (m_busy != 0 && m_cnt == 0) ? ((m_g == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_ack", ack, exp_ack);
      if (exp_ack != 0) begin
        chk("rnd_err", err, m_err);
        if (m_chk) chk("rnd_rdata", rdata, m_rd);
        chk("rnd_txn", txn_count, m_count);
      end
      for (int r = 0; r < 2; r++) begin
        if ((exp_ack[r] || !b_req[r]) && ($urandom_range(1, 0) == 1)) begin
          set_req(r, $urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), $urandom);
        end else if (exp_ack[r]) begin
          b_req[r] = 1'b0;
        end
      end
      if (m_busy != 0) begin
        if (m_cnt == 0) begin
          m_busy = 0;
          if (m_count < 65535) m_count++;
        end else begin
          m_cnt--;
        end
      end else if (b_req != 0) begin
        int a;
        m_g = (b_req == 2'b11) ? 1 - last_g : (b_req[1] ? 1 : 0);
        last_g = m_g;
        a = int'(b_addr[m_g*2 +: 2]);
        if (b_we[m_g]) begin
          if (a != 1) ref_mem[a] = b_wdata[m_g*32 +: 32];
          m_rd = (a == 1) ? 32'h0 : ref_mem[a];
          m_chk = RB;
          m_err = RB && (m_rd != b_wdata[m_g*32 +: 32]);
          m_cnt = RB ? 2 : 1;
        end else begin
          m_rd = (a == 1) ? 32'h0 : ref_mem[a];
          m_chk = 1'b1;
          m_err = 1'b0;
          m_cnt = 1;
        end
        m_busy = 1;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
